// File: rtl/acc_unit_pkg.sv
// acc_unit_pkg: opcode and FSM state types shared by the accumulator unit
package acc_unit_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;
endpackage

// File: rtl/acc_unit_alu.sv
// acc_unit_alu: single-cycle ADD..NOT datapath; ACC_UNIT_SAT_EN enables ADD/SUB saturation
module acc_unit_alu
  import acc_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             cy_o
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  // result and carry/borrow; the MSB of the widened difference is the borrow
  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i};
    dif   = {1'b0, a_i} - {1'b0, b_i};
    res_o = '0;
    cy_o  = 1'b0;
    case (op_i)
      OP_ADD: begin res_o = sum[WIDTH-1:0]; cy_o = sum[WIDTH]; end
      OP_SUB: begin res_o = dif[WIDTH-1:0]; cy_o = dif[WIDTH]; end
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_NOT: res_o = ~a_i;
      default: res_o = a_i;
    endcase
`ifdef ACC_UNIT_SAT_EN
    if (op_i == OP_ADD && sum[WIDTH]) res_o = '1;
    if (op_i == OP_SUB && dif[WIDTH]) res_o = '0;
`endif
  end
endmodule

// File: rtl/acc_unit.sv
// acc_unit: accumulator with ALU ops and bit-serial shifter; ACC_UNIT_SAT_EN selects saturating ADD/SUB
module acc_unit
  import acc_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cl,
  input  logic             ld,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   shamt,
  input  logic             fill,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             zero
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             shl_q, shl_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;
  op_e              op_s;

  assign op_s = op_e'(op);

  acc_unit_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i  (op_s),
    .a_i   (acc_q),
    .b_i   (operand),
    .res_o (alu_res),
    .cy_o  (alu_cy)
  );

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      shl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      shl_q   <= shl_d;
    end
  end

  // next state: clear beats start beats load; shifts move one bit per SHIFT cycle
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    shl_d   = shl_q;
    if (cl) begin
      state_d = S_IDLE;
      acc_d   = '0;
      carry_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (op_s == OP_SHL || op_s == OP_SHR) begin
              shl_d   = (op_s == OP_SHL);
              cnt_d   = shamt;
              state_d = (shamt == '0) ? S_DONE : S_SHIFT;
            end else begin
              acc_d   = alu_res;
              carry_d = alu_cy;
              state_d = S_DONE;
            end
          end else if (ld) begin
            acc_d = operand;
          end
        end
        S_SHIFT: begin
          acc_d   = shl_q ? {acc_q[WIDTH-2:0], fill} : {fill, acc_q[WIDTH-1:1]};
          carry_d = shl_q ? acc_q[WIDTH-1] : acc_q[0];
          cnt_d   = cnt_q - SHW'(1);
          state_d = (cnt_q == SHW'(1)) ? S_DONE : S_SHIFT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_DONE);
  assign acc   = acc_q;
  assign carry = carry_q;
  assign zero  = (acc_q == '0);
endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: directed self-checking bench for acc_unit at WIDTH=8
module tb_acc_unit;
  import acc_unit_pkg::*;
  logic       clk, rst_n, cl, ld, start, fill;
  logic [2:0] op, shamt;
  logic [7:0] operand;
  logic       ready, done, carry, zero;
  logic [7:0] acc;
  int pass_cnt = 0;
  int total_cnt = 0;
`ifdef ACC_UNIT_SAT_EN
  localparam logic [7:0] ADD_EXP = 8'hFF;
  localparam logic [7:0] SUB_EXP = 8'h00;
`else
  localparam logic [7:0] ADD_EXP = 8'h10;
  localparam logic [7:0] SUB_EXP = 8'hFE;
`endif

  acc_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .start(start), .op(op),
    .operand(operand), .shamt(shamt), .fill(fill), .ready(ready), .done(done),
    .acc(acc), .carry(carry), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ld(input logic [7:0] d);
    @(negedge clk);
    ld = 1'b1;
    operand = d;
    tick();
    ld = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] o, input logic [7:0] d, input logic [2:0] s, input logic f);
    @(negedge clk);
    start = 1'b1;
    op = o;
    operand = d;
    shamt = s;
    fill = f;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total_cnt++; if (acc !== 8'h00) $display("FAIL reset_acc got %h exp 00", acc); else pass_cnt++;
    total_cnt++; if (carry !== 1'b0) $display("FAIL reset_carry got %b exp 0", carry); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1) $display("FAIL reset_zero got %b exp 1", zero); else pass_cnt++;
    total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", ready); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    total_cnt++; if (acc !== 8'h00) $display("FAIL idle_acc got %h exp 00", acc); else pass_cnt++;
    total_cnt++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL idle_flags got ready=%b done=%b exp 1/0", ready, done); else pass_cnt++;
  endtask

  task automatic test_add();
    do_ld(8'hA5);
    total_cnt++; if (acc !== 8'hA5) $display("FAIL ld_acc got %h exp a5", acc); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL ld_done got %b exp 0", done); else pass_cnt++;
    do_start(OP_ADD, 8'h6B, 3'd0, 1'b0);
    total_cnt++; if (acc !== ADD_EXP) $display("FAIL add_acc got %h exp %h", acc, ADD_EXP); else pass_cnt++;
    total_cnt++; if (carry !== 1'b1) $display("FAIL add_carry got %b exp 1", carry); else pass_cnt++;
    total_cnt++; if (done !== 1'b1 || ready !== 1'b0) $display("FAIL add_done got done=%b ready=%b exp 1/0", done, ready); else pass_cnt++;
    ld = 1'b1;
    operand = 8'h55;
    tick();
    ld = 1'b0;
    total_cnt++; if (acc !== ADD_EXP) $display("FAIL ld_in_done got %h exp %h", acc, ADD_EXP); else pass_cnt++;
    total_cnt++; if (done !== 1'b0 || ready !== 1'b1) $display("FAIL add_after got done=%b ready=%b exp 0/1", done, ready); else pass_cnt++;
  endtask

  task automatic test_sub();
    do_ld(8'h05);
    do_start(OP_SUB, 8'h07, 3'd0, 1'b0);
    total_cnt++; if (acc !== SUB_EXP) $display("FAIL sub_acc got %h exp %h", acc, SUB_EXP); else pass_cnt++;
    total_cnt++; if (carry !== 1'b1) $display("FAIL sub_borrow got %b exp 1", carry); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL sub_done got %b exp 1", done); else pass_cnt++;
    tick();
  endtask

  task automatic test_shamt0();
    do_start(OP_SHR, 8'h00, 3'd0, 1'b1);
    total_cnt++; if (acc !== SUB_EXP) $display("FAIL sh0_acc got %h exp %h", acc, SUB_EXP); else pass_cnt++;
    total_cnt++; if (carry !== 1'b1) $display("FAIL sh0_carry got %b exp 1", carry); else pass_cnt++;
    total_cnt++; if (done !== 1'b1) $display("FAIL sh0_done got %b exp 1", done); else pass_cnt++;
    tick();
  endtask

  task automatic test_logic();
    do_ld(8'hF0);
    do_start(OP_AND, 8'h3C, 3'd0, 1'b0);
    total_cnt++; if (acc !== 8'h30 || carry !== 1'b0) $display("FAIL and got acc=%h carry=%b exp 30/0", acc, carry); else pass_cnt++;
    tick();
    do_start(OP_XOR, 8'hFF, 3'd0, 1'b0);
    total_cnt++; if (acc !== 8'hCF) $display("FAIL xor got %h exp cf", acc); else pass_cnt++;
    tick();
    do_start(OP_NOT, 8'h00, 3'd0, 1'b0);
    total_cnt++; if (acc !== 8'h30) $display("FAIL not got %h exp 30", acc); else pass_cnt++;
    tick();
    do_start(OP_OR, 8'h0F, 3'd0, 1'b0);
    total_cnt++; if (acc !== 8'h3F) $display("FAIL or got %h exp 3f", acc); else pass_cnt++;
    tick();
  endtask

  task automatic test_shl();
    do_ld(8'h81);
    do_start(OP_SHL, 8'h00, 3'd3, 1'b1);
    total_cnt++; if (acc !== 8'h81 || ready !== 1'b0 || done !== 1'b0) $display("FAIL shl_accept got acc=%h ready=%b done=%b exp 81/0/0", acc, ready, done); else pass_cnt++;
    start = 1'b1;
    op = OP_ADD;
    operand = 8'h01;
    tick();
    total_cnt++; if (acc !== 8'h03 || carry !== 1'b1 || ready !== 1'b0) $display("FAIL shl_1 got acc=%h carry=%b ready=%b exp 03/1/0", acc, carry, ready); else pass_cnt++;
    tick();
    start = 1'b0;
    total_cnt++; if (acc !== 8'h07 || carry !== 1'b0 || done !== 1'b0) $display("FAIL shl_2 got acc=%h carry=%b done=%b exp 07/0/0", acc, carry, done); else pass_cnt++;
    tick();
    total_cnt++; if (acc !== 8'h0F || carry !== 1'b0 || done !== 1'b1) $display("FAIL shl_3 got acc=%h carry=%b done=%b exp 0f/0/1", acc, carry, done); else pass_cnt++;
    tick();
    total_cnt++; if (acc !== 8'h0F || ready !== 1'b1 || done !== 1'b0) $display("FAIL shl_end got acc=%h ready=%b done=%b exp 0f/1/0", acc, ready, done); else pass_cnt++;
  endtask

  task automatic test_shr_clear();
    do_ld(8'hFF);
    do_start(OP_SHR, 8'h00, 3'd7, 1'b0);
    tick();
    total_cnt++; if (acc !== 8'h7F || carry !== 1'b1) $display("FAIL shr_1 got acc=%h carry=%b exp 7f/1", acc, carry); else pass_cnt++;
    tick();
    total_cnt++; if (acc !== 8'h3F || carry !== 1'b1) $display("FAIL shr_2 got acc=%h carry=%b exp 3f/1", acc, carry); else pass_cnt++;
    @(negedge clk);
    cl = 1'b1;
    tick();
    cl = 1'b0;
    total_cnt++; if (acc !== 8'h00 || carry !== 1'b0 || zero !== 1'b1) $display("FAIL clr_state got acc=%h carry=%b zero=%b exp 00/0/1", acc, carry, zero); else pass_cnt++;
    total_cnt++; if (ready !== 1'b1 || done !== 1'b0) $display("FAIL clr_flags got ready=%b done=%b exp 1/0", ready, done); else pass_cnt++;
    tick();
    total_cnt++; if (done !== 1'b0 || acc !== 8'h00) $display("FAIL clr_after got done=%b acc=%h exp 0/00", done, acc); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_ld(8'hAA);
    do_start(OP_SHR, 8'h00, 3'd5, 1'b1);
    tick();
    total_cnt++; if (acc !== 8'hD5 || ready !== 1'b0) $display("FAIL ars_shift got acc=%h ready=%b exp d5/0", acc, ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++; if (acc !== 8'h00 || ready !== 1'b1 || zero !== 1'b1) $display("FAIL ars_async got acc=%h ready=%b zero=%b exp 00/1/1", acc, ready, zero); else pass_cnt++;
    total_cnt++; if (done !== 1'b0 || carry !== 1'b0) $display("FAIL ars_flags got done=%b carry=%b exp 0/0", done, carry); else pass_cnt++;
    #1;
    rst_n = 1'b1;
    tick();
    do_start(OP_ADD, 8'h22, 3'd0, 1'b0);
    total_cnt++; if (acc !== 8'h22 || carry !== 1'b0 || done !== 1'b1) $display("FAIL ars_add got acc=%h carry=%b done=%b exp 22/0/1", acc, carry, done); else pass_cnt++;
    tick();
    total_cnt++; if (ready !== 1'b1 || acc !== 8'h22) $display("FAIL ars_idle got ready=%b acc=%h exp 1/22", ready, acc); else pass_cnt++;
  endtask

  initial begin
    cl = 1'b0;
    ld = 1'b0;
    start = 1'b0;
    op = 3'd0;
    operand = 8'h00;
    shamt = 3'd0;
    fill = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_shamt0();
    test_logic();
    test_shl();
    test_shr_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
